// File: rtl/rns_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rns_pkg: residue types, modular helpers and FSM states for the RNS FIR   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package rns_pkg;

    localparam int CH    = 4;
    localparam int RES_W = 8;

    typedef logic [RES_W-1:0] residue_t;
    typedef residue_t [CH-1:0] rns_word_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A single subtract is enough because every 8-bit value is below 2*m for m >= 129.
    function automatic residue_t rns_reduce(input residue_t r, input residue_t m);
        return (r >= m) ? residue_t'(r - m) : r;
    endfunction

    function automatic residue_t mod_add(input residue_t a, input residue_t b, input residue_t m);
        logic [RES_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, m}) begin
            s = s - {1'b0, m};
        end
        return s[RES_W-1:0];
    endfunction

    function automatic residue_t mod_mul(input residue_t a, input residue_t b, input residue_t m);
        logic [2*RES_W-1:0] p;
        p = {{RES_W{1'b0}}, a} * {{RES_W{1'b0}}, b};
        return residue_t'(p % {{RES_W{1'b0}}, m});
    endfunction

    function automatic int unsigned gcd(input int unsigned a, input int unsigned b);
        int unsigned u;
        int unsigned v;
        int unsigned t;
        u = a;
        v = b;
        while (v != 0) begin
            t = u % v;
            u = v;
            v = t;
        end
        return u;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rns_mod_mac.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rns_mod_mac: one residue channel, registered modular multiply-accumulate |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rns_mod_mac
    import rns_pkg::*;
#(
    parameter int unsigned M = 233
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     clr,
    input  logic     en,
    input  residue_t c,
    input  residue_t d,
    output residue_t acc_nxt
);

    localparam residue_t MR = residue_t'(M);

    residue_t acc_q;
    residue_t acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = mod_add(acc_q, mod_mul(c, d, MR), MR);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // The top captures y from the post-tap value so the last tap and y land on one edge.
    assign acc_nxt = acc_d;

endmodule
`default_nettype wire

// File: rtl/fir_rns_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fir_rns_seq: time-multiplexed RNS FIR, one MAC per channel, TAPS cycles  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fir_rns_seq
    import rns_pkg::*;
#(
    parameter int unsigned M0   = 233,
    parameter int unsigned M1   = 239,
    parameter int unsigned M2   = 241,
    parameter int unsigned M3   = 251,
    parameter int unsigned TAPS = 8,
    localparam int AW           = $clog2(TAPS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [31:0]   x,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [31:0]   y,
    output logic          out_valid,
    input  logic          out_ready,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [31:0]   coef_data
);

    localparam int unsigned   MOD [CH] = '{M0, M1, M2, M3};
    localparam logic [AW-1:0] K_LAST   = AW'(TAPS - 1);
    localparam rns_word_t     C0_INIT  = 32'h01010101;

    if (TAPS < 2 || TAPS > 64) begin : g_bad_taps
        $error("fir_rns_seq: TAPS must lie in 2..64");
    end
    if (M0 < 129 || M0 > 255 || M1 < 129 || M1 > 255 ||
        M2 < 129 || M2 > 255 || M3 < 129 || M3 > 255) begin : g_bad_range
        $error("fir_rns_seq: every modulus must lie in 129..255");
    end
    if (gcd(M0, M1) != 1 || gcd(M0, M2) != 1 || gcd(M0, M3) != 1 ||
        gcd(M1, M2) != 1 || gcd(M1, M3) != 1 || gcd(M2, M3) != 1) begin : g_bad_coprime
        $error("fir_rns_seq: moduli must be pairwise coprime");
    end

    state_t        state_q, state_d;
    logic [AW-1:0] k_q, k_d;
    rns_word_t     d_q [TAPS];
    rns_word_t     d_d [TAPS];
    rns_word_t     c_q [TAPS];
    rns_word_t     c_d [TAPS];
    rns_word_t     y_q, y_d;
    rns_word_t     x_red, coef_red, acc_nxt;
    logic          mac_clr, mac_en;
    logic          addr_ok;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        assign x_red[g]    = rns_reduce(x[g*RES_W +: RES_W], residue_t'(MOD[g]));
        assign coef_red[g] = rns_reduce(coef_data[g*RES_W +: RES_W], residue_t'(MOD[g]));

        rns_mod_mac #(
            .M (MOD[g])
        ) u_mac (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (mac_clr),
            .en      (mac_en),
            .c       (c_q[k_q][g]),
            .d       (d_q[k_q][g]),
            .acc_nxt (acc_nxt[g])
        );
    end

    // Guards the bank when TAPS is not a power of two.
    assign addr_ok = ({1'b0, coef_addr} < (AW+1)'(TAPS));

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        d_d     = d_q;
        c_d     = c_q;
        y_d     = y_q;
        mac_clr = 1'b0;
        mac_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (coef_we && addr_ok) begin
                    c_d[coef_addr] = coef_red;
                end
                if (in_valid) begin
                    d_d[0] = x_red;
                    for (int i = 1; i < TAPS; i++) begin
                        d_d[i] = d_q[i-1];
                    end
                    mac_clr = 1'b1;
                    k_d     = '0;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                mac_en = 1'b1;
                if (k_q == K_LAST) begin
                    y_d     = acc_nxt;
                    k_d     = '0;
                    state_d = ST_DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            y_q     <= '0;
            for (int i = 0; i < TAPS; i++) begin
                d_q[i] <= '0;
                c_q[i] <= (i == 0) ? C0_INIT : '0;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            y_q     <= y_d;
            d_q     <= d_d;
            c_q     <= c_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign y         = y_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_rns_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fir_rns_seq: directed vectors, queue scoreboard with separate monitor |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fir_rns_seq;

    localparam int TAPS = 8;
    localparam int AW   = $clog2(TAPS);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   x;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   y;
    logic          out_valid;
    logic          out_ready;
    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic [31:0]   coef_data;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q [$];
    time         acc_t_q [$];
    logic        prev_ov = 1'b0;

    always #5 clk = ~clk;

    fir_rns_seq #(
        .TAPS (TAPS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x         (x),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL wait_idle: in_ready=%b after %0d cycles", in_ready, n);
        end
    endtask

    task automatic send(input logic [31:0] xv, input logic [31:0] expv);
        wait_idle();
        exp_q.push_back(expv);
        x        = xv;
        in_valid = 1'b1;
        @(posedge clk);
        acc_t_q.push_back($time);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic write_coef(input logic [AW-1:0] a, input logic [31:0] v);
        wait_idle();
        coef_we   = 1'b1;
        coef_addr = a;
        coef_data = v;
        @(posedge clk);
        #1;
        coef_we = 1'b0;
    endtask

    // Monitor: latency on each rising out_valid, value on each handshake.
    initial begin
        time t;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && !prev_ov) begin
                if (acc_t_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid: out_valid=1 with no accepted sample");
                end else begin
                    t = acc_t_q.pop_front();
                    check("latency", 32'($time - t), 32'(TAPS * 10 + 5));
                end
            end
            prev_ov = out_valid;
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_y: y=%h with empty scoreboard", y);
                end else begin
                    check("y", y, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int n;
        x         = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_y", y, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        send(32'h05050505, 32'h05050505);
        send(32'h050505FF, 32'h05050516);

        // Backpressure: hold the result for five cycles with a competing sample offered.
        wait_idle();
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(32'h03030303, 32'h03030303);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        x        = 32'hFFFFFFFF;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", {31'b0, out_valid}, 32'd1);
            check("bp_y", y, 32'h03030303);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        x         = '0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
        check("bp_release_out_valid", {31'b0, out_valid}, 32'd0);

        // Flush the delay line so taps 1..3 hold zero before the impulse.
        for (int i = 0; i < 3; i++) begin
            send(32'h0, 32'h0);
        end

        write_coef(0, 32'h01010101);
        write_coef(1, 32'h02020202);
        write_coef(2, 32'h03030303);
        write_coef(3, 32'h04040404);
        send(32'h01010101, 32'h01010101);
        send(32'h00000000, 32'h02020202);
        send(32'h00000000, 32'h03030303);
        send(32'h00000000, 32'h04040404);
        send(32'h00000000, 32'h00000000);

        write_coef(0, 32'hC8C8C8C8);
        write_coef(1, 32'h0);
        write_coef(2, 32'h0);
        write_coef(3, 32'h0);
        send(32'hC8C8C8C8, 32'h5BEB579D);

        // Reset three cycles into a sample: no output, identity bank restored.
        wait_idle();
        x        = 32'hAAAAAAAA;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_y", y, 32'h0);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        send(32'h07070707, 32'h07070707);

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d outputs still pending", exp_q.size());
        end
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fir_rns_seq.md
# fir_rns_seq

Parametrised, time-multiplexed RNS FIR filter: one modular multiply-accumulate per residue channel, iterated over TAPS coefficients per input sample. It has a valid/ready handshake on both sides and a runtime-writable coefficient bank. It sits between the int→RNS and RNS→int convertors. It is the successor to the fixed single-cycle RNS FIR: tap count is a parameter, it supports backpressure and coefficient reload, and it saves area through one MAC per channel.

## Interface
- M0, 233: channel-0 modulus, bits [7:0]
- M1, 239: channel-1 modulus, bits [15:8]
- M2, 241: channel-2 modulus, bits [23:16]
- M3, 251: channel-3 modulus, bits [31:24]
- TAPS, 8: filter length, 2..64
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low (asserted at 0)
- x  in  32  input sample, four packed 8-bit residues
- in_valid  in  1  x valid
- in_ready  out  1  block can accept x
- y  out  32  filtered output, packed residues
- out_valid  out  1  y valid
- out_ready  in  1  consumer takes y
- coef_we  in  1  coefficient write strobe
- coef_addr  in  $clog2(TAPS)  tap index
- coef_data  in  32  packed coefficient residues

## Operation
- Moduli are pairwise coprime and lie in 129..255. Elaboration-time assertions check both conditions.
- Any 8-bit residue r ≥ Mi (on x or coef_data) is reduced once at capture: r − Mi. This is valid because r < 2·Mi.
- Delay line d[0..TAPS-1] and coefficient bank c[0..TAPS-1] are each 32-bit packed.
- Each channel computes acc = (acc + (c[k]·d[k] mod Mi)) mod Mi.
  - The product is 16 bits, reduced by constant modulus.
  - The addition uses a 9-bit sum with a conditional subtract.
- FSM states are IDLE, MAC and DONE.
- **IDLE:** in_ready=1.
  - On in_valid: shift d (d[0]←reduced x, d[k]←d[k-1]), clear acc, set k=0, go to MAC.
- **MAC:** perform one tap per cycle and increment k.
  - After the tap with k=TAPS-1, register acc into y, set out_valid=1, go to DONE.
- **DONE:** y and out_valid are held.
  - On out_ready, clear out_valid and go to IDLE.
  - in_valid is ignored in MAC and in DONE.
- **Coefficient writes:**
  - coef_we takes effect only in IDLE and is ignored otherwise.
  - c[coef_addr]←reduced coef_data.
  - If coef_we and in_valid occur in the same IDLE cycle, the new coefficient is used for that sample.
  - coef_addr ≥ TAPS is ignored.
- **Reset values:**
  - state=IDLE, in_ready=1, out_valid=0, y=0, k=0, acc=0, all d=0.
  - c[0]=32'h01010101 and all other c=0, giving an identity filter.
- Reset asserted mid-MAC or in DONE aborts the sample with no output, and all registers return to their reset values.

## Timing
- Accept at edge A: the MAC runs on edges A+1..A+TAPS, and out_valid is high after edge A+TAPS.
- Latency is TAPS cycles.
- Throughput is at most 1 sample per TAPS+2 cycles (accept, TAPS MACs, DONE with out_ready=1).
- y changes only on the edge that sets out_valid. It is stable for the whole DONE stay.
- in_ready and out_valid are decoded from registered state. There is no combinational path from in_valid or out_ready to any output.

## Structure
- Package rns_pkg holds:
  - constants CH=4 and RES_W=8;
  - typedef residue_t (logic [7:0]) and typedef rns_word_t (residue_t [CH-1:0]);
  - functions rns_reduce, mod_add and mod_mul;
  - the FSM state enum.
- Sub-module rns_mod_mac holds the single-channel registered acc/clear/enable datapath, parameterised by modulus M. It is instantiated four times.
- The top level holds the FSM, tap counter, delay line and coefficient bank.

## Test plan
- **Identity after reset:** x=32'h05050505 accepted → after TAPS cycles, y=32'h05050505 and out_valid=1.
- **Impulse response:**
  - Write c[0..3]=32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404, with other taps 0.
  - Feed x=32'h01010101, then four zero samples.
  - Required y sequence: 01010101, 02020202, 03030303, 04040404, 00000000.
- **Modular wrap:**
  - c[0]=32'hC8C8C8C8 (200), rest 0; x=32'hC8C8C8C8.
  - Required y=32'h5BEB579D, i.e. residues 157, 87, 235, 91 for channels 0..3.
- **Backpressure:**
  - Hold out_ready=0 for 5 cycles in DONE.
  - Required: y and out_valid stable, in_ready=0, and a concurrent in_valid sample is not accepted (d unchanged).
  - Release out_ready → IDLE next cycle.
- **Range reduction:** identity filter with x=32'h050505FF → y=32'h05050516 (255−233=22).
- **Reset mid-MAC:**
  - Drop reset 3 cycles after an accept.
  - Required: out_valid=0, y=0, in_ready=1, and c back to identity.
  - After release, x=32'h07070707 → y=32'h07070707.
